dmem_access_unit: RTL and testbench

Memory-stage data-memory access unit for the three-stage RISC-V core. It consumes the memory-stage control outputs (store byte mask, load enable, funct3) together with the address and store data. It drives a valid/ready request / valid response handshake toward the data cache and stalls the pipeline until the access finishes. It returns sign- or zero-extended load data for writeback, so it is the responder to the memory-stage control decode.

---
 rtl/dmem_access_unit.sv | 157 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : Memory-stage data access unit; shifts stores, extends loads,
//               and runs a valid/ready handshake to the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  w_mask,
    input  logic        re,
    input  logic [2:0]  funct3,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [29:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_is_store;
    logic        w_is_noop;
    logic        w_accept;
    logic [3:0]  w_mask_shift;
    logic [31:0] w_data_shift;
    logic [31:0] w_rdata_shift;
    logic [31:0] w_load_ext;

    logic        r_rw;
    logic [29:0] r_word;
    logic [31:0] r_data;
    logic [3:0]  r_mask;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic [31:0] r_resp_data;

    // A nonzero mask wins over re, so a store never also loads.
    assign w_is_store    = |w_mask;
    assign w_is_noop     = ~w_is_store & ~re;
    assign w_accept      = (r_state == IDLE) && req_valid;
    assign w_mask_shift  = w_mask << addr[1:0];
    assign w_data_shift  = wdata << {addr[1:0], 3'b000};
    assign w_rdata_shift = mem_resp_data >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_rdata_shift;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_rdata_shift[7]}}, w_rdata_shift[7:0]};
            3'b100:  w_load_ext = {24'd0, w_rdata_shift[7:0]};
            3'b001:  w_load_ext = {{16{w_rdata_shift[15]}}, w_rdata_shift[15:0]};
            3'b101:  w_load_ext = {16'd0, w_rdata_shift[15:0]};
            default: w_load_ext = w_rdata_shift;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        stall         = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stall        = ~w_is_noop;
                    w_state_next = w_is_noop ? DONE : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                stall         = 1'b1;
                if (mem_req_ready) begin
                    w_state_next = r_rw ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                resp_valid   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw        <= 1'b0;
            r_word      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_rw     <= w_is_store;
                r_word   <= addr[31:2];
                r_data   <= w_data_shift;
                r_mask   <= w_mask_shift;
                r_off    <= addr[1:0];
                r_funct3 <= funct3;
                if (w_is_noop) begin
                    r_resp_data <= '0;
                end
            end
            // Stores and no-ops report zero; loads report the extended word.
            if ((r_state == REQ) && mem_req_ready && r_rw) begin
                r_resp_data <= '0;
            end
            if ((r_state == WAIT) && mem_resp_valid) begin
                r_resp_data <= w_load_ext;
            end
        end
    end

    assign mem_req_rw   = r_rw;
    assign mem_req_addr = r_word;
    assign mem_req_data = r_data;
    assign mem_req_mask = r_mask;
    assign resp_data    = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Directed vector bench for dmem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  w_mask;
    logic        re;
    logic [2:0]  funct3;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_access_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .addr           (addr),
        .wdata          (wdata),
        .w_mask         (w_mask),
        .re             (re),
        .funct3         (funct3),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  w_mask;
        logic        re;
        logic [2:0]  funct3;
        logic [31:0] rdata;
        logic [3:0]  exp_mask;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic        exp_noop;
        logic [31:0] exp_resp;
        int          rdly;
        int          wdly;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts in an IDLE cycle (#1 after an edge) and returns in the next IDLE cycle.
    task automatic do_access(input vec_t v);
        int  req_cnt;
        int  wait_cnt;
        int  lat;
        int  exp_lat;
        bit  in_wait;
        bit  hs_pending;
        bit  done;
        exp_lat = v.exp_noop ? 1 : (v.exp_rw ? 2 + v.rdly : 3 + v.rdly + v.wdly);
        req_valid      = 1'b1;
        addr           = v.addr;
        wdata          = v.wdata;
        w_mask         = v.w_mask;
        re             = v.re;
        funct3         = v.funct3;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = ~v.rdata;
        #1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        check("stall_accept", {31'd0, stall}, {31'd0, ~v.exp_noop});
        req_cnt = 0; wait_cnt = 0; in_wait = 0; hs_pending = 0; done = 0; lat = -1;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            req_valid      = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = ~v.rdata;
            if (hs_pending) begin
                hs_pending = 0;
                in_wait    = !v.exp_rw;
            end
            if (resp_valid) begin
                lat  = c;
                done = 1;
                check("resp_data", resp_data, v.exp_resp);
                check("stall_done", {31'd0, stall}, 32'd0);
                check("latency", lat, exp_lat);
            end else if (mem_req_valid) begin
                check("req_on_noop", {31'd0, mem_req_valid}, {31'd0, ~v.exp_noop});
                check("req_addr", {2'b00, mem_req_addr}, v.addr >> 2);
                check("req_mask", {28'd0, mem_req_mask}, {28'd0, v.exp_mask});
                check("req_data", mem_req_data, v.exp_data);
                check("req_rw", {31'd0, mem_req_rw}, {31'd0, v.exp_rw});
                check("stall_req", {31'd0, stall}, 32'd1);
                if (req_cnt >= v.rdly) begin
                    mem_req_ready = 1'b1;
                    hs_pending    = 1;
                end
                req_cnt++;
            end else if (in_wait) begin
                check("stall_wait", {31'd0, stall}, 32'd1);
                if (wait_cnt >= v.wdly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = v.rdata;
                end
                wait_cnt++;
            end
        end
        check("completed", {31'd0, done}, 32'd1);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        check("resp_once", {31'd0, resp_valid}, 32'd0);
        check("req_ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
        check({tag, "_mem_req_rw"}, {31'd0, mem_req_rw}, 32'd0);
        check({tag, "_mem_req_addr"}, {2'b00, mem_req_addr}, 32'd0);
        check({tag, "_mem_req_data"}, mem_req_data, 32'd0);
        check({tag, "_mem_req_mask"}, {28'd0, mem_req_mask}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        //         addr        wdata         mask    re    f3      rdata         emask   edata         rw    noop  resp          rdly wdly
        tbl[0]  = '{32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 3'b010, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        0, 0};
        tbl[1]  = '{32'h103, 32'h000000A5, 4'b0001, 1'b0, 3'b000, 32'h0,        4'b1000, 32'hA5000000, 1'b1, 1'b0, 32'h0,        1, 0};
        tbl[2]  = '{32'h103, 32'h00001234, 4'b0011, 1'b0, 3'b001, 32'h0,        4'b1000, 32'h34000000, 1'b1, 1'b0, 32'h0,        0, 0};
        tbl[3]  = '{32'h202, 32'h0000BEEF, 4'b0011, 1'b0, 3'b001, 32'h0,        4'b1100, 32'hBEEF0000, 1'b1, 1'b0, 32'h0,        0, 0};
        tbl[4]  = '{32'h010, 32'h0,        4'b0000, 1'b0, 3'b000, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 32'h0,        0, 0};
        tbl[5]  = '{32'h102, 32'h0,        4'b0000, 1'b1, 3'b000, 32'h8081F0F1, 4'b0000, 32'h0,        1'b0, 1'b0, 32'hFFFFFF81, 0, 0};
        tbl[6]  = '{32'h102, 32'h0,        4'b0000, 1'b1, 3'b100, 32'h8081F0F1, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h00000081, 0, 2};
        tbl[7]  = '{32'h102, 32'h0,        4'b0000, 1'b1, 3'b001, 32'h8081F0F1, 4'b0000, 32'h0,        1'b0, 1'b0, 32'hFFFF8081, 0, 0};
        tbl[8]  = '{32'h102, 32'h0,        4'b0000, 1'b1, 3'b101, 32'h8081F0F1, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h00008081, 0, 0};
        tbl[9]  = '{32'h100, 32'h0,        4'b0000, 1'b1, 3'b010, 32'h8081F0F1, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h8081F0F1, 0, 0};
        tbl[10] = '{32'h008, 32'h11223344, 4'b1111, 1'b1, 3'b000, 32'h0,        4'b1111, 32'h11223344, 1'b1, 1'b0, 32'h0,        0, 0};
        tbl[11] = '{32'h101, 32'h0,        4'b0000, 1'b1, 3'b000, 32'h00007F00, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h0000007F, 0, 0};
        // Ready low for 3 REQ cycles, response on the 4th WAIT cycle: resp_valid at cycle 9.
        tbl[12] = '{32'h104, 32'h0,        4'b0000, 1'b1, 3'b011, 32'h12345678, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h12345678, 3, 3};

        reset          = 1'b1;
        req_valid      = 1'b0;
        addr           = '0;
        wdata          = '0;
        w_mask         = '0;
        re             = 1'b0;
        funct3         = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            do_access(tbl[i]);
        end

        // Reset in WAIT, then a stale response that must be ignored.
        req_valid = 1'b1; addr = 32'h100; wdata = '0; w_mask = 4'b0000; re = 1'b1; funct3 = 3'b010;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_req", {31'd0, mem_req_valid}, 32'd1);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("abort_in_wait", {31'd0, mem_req_valid}, 32'd0);
        check("abort_wait_stall", {31'd0, stall}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clk); #1;
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stale_resp_valid", {31'd0, resp_valid}, 32'd0);
            check("stale_resp_data", resp_data, 32'd0);
        end
        mem_resp_valid = 1'b0;
        do_access('{32'h104, 32'h0, 4'b0000, 1'b1, 3'b010, 32'hCAFEF00D, 4'b0000, 32'h0,
                    1'b0, 1'b0, 32'hCAFEF00D, 0, 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
